// File: rtl/reg_bank_pkg.sv
// Shared constants and FSM encoding for the parametrised register bank.
package reg_bank_pkg;
  localparam int RV32E_NREGS = 16;
  localparam int RV32I_NREGS = 32;
  localparam int XLEN        = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/reg_bank_scoreboard.sv
// Per-register pending bits for hazard detection; set wins over clear on the same index.
// REG_BANK_BYPASS_EN: a same-cycle writeback hides the pending bit it is about to clear.
module reg_bank_scoreboard #(
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          wreg,
  input  logic [AW-1:0] write_reg,
  input  logic          mark,
  input  logic [AW-1:0] mark_reg,
  input  logic [AW-1:0] read_reg1,
  input  logic [AW-1:0] read_reg2,
  output logic          pend1,
  output logic          pend2
);
  logic [NREGS-1:0] pend_q, pend_d;
  logic             clr_hit, set_hit;

  assign clr_hit = en && wreg && (write_reg != '0);
  assign set_hit = en && mark && (mark_reg != '0);

  always_comb begin
    pend_d = pend_q;
    if (clr_hit) pend_d[write_reg] = 1'b0;
    // A newly issued producer supersedes the one retiring this cycle.
    if (set_hit) pend_d[mark_reg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  always_comb begin
    pend1 = en && pend_q[read_reg1];
    pend2 = en && pend_q[read_reg2];
`ifdef REG_BANK_BYPASS_EN
    if (clr_hit && !(set_hit && mark_reg == write_reg)) begin
      if (read_reg1 == write_reg) pend1 = 1'b0;
      if (read_reg2 == write_reg) pend2 = 1'b0;
    end
`endif
  end
endmodule

// File: rtl/reg_bank_sb.sv
// Decode-stage register bank: post-reset clear sweep, 2 comb read ports, 1 write port, scoreboard.
// REG_BANK_BYPASS_EN: forward same-cycle writeback data onto the read ports.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter  int NREGS = RV32E_NREGS,
  parameter  int WIDTH = XLEN,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    read_reg1,
  input  logic [AW-1:0]    read_reg2,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2,
  input  logic [AW-1:0]    write_reg,
  input  logic             wreg,
  input  logic [WIDTH-1:0] write_data,
  input  logic [AW-1:0]    mark_reg,
  input  logic             mark,
  output logic             pend1,
  output logic             pend2,
  output logic             ready
);
  state_e           state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic             we;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + AW'(1);
      if (clr_ptr_q == AW'(NREGS - 1)) state_d = ST_RUN;
    end
  end

  assign ready = (state_q == ST_RUN);
  assign we    = ready && wreg && (write_reg != '0);

  // Storage needs no reset: the sweep zeroes it before any read is exposed.
  always_ff @(posedge clock) begin
    if (!ready)  regs_q[clr_ptr_q] <= '0;
    else if (we) regs_q[write_reg] <= write_data;
  end

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (ready && read_reg1 != '0) read_data1 = regs_q[read_reg1];
    if (ready && read_reg2 != '0) read_data2 = regs_q[read_reg2];
`ifdef REG_BANK_BYPASS_EN
    if (we && read_reg1 == write_reg) read_data1 = write_data;
    if (we && read_reg2 == write_reg) read_data2 = write_data;
`endif
  end

  reg_bank_scoreboard #(.NREGS(NREGS)) u_sb (
    .clock     (clock),
    .reset     (reset),
    .en        (ready),
    .wreg      (wreg),
    .write_reg (write_reg),
    .mark      (mark),
    .mark_reg  (mark_reg),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .pend1     (pend1),
    .pend2     (pend2)
  );
endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed + random bench for reg_bank_sb (NREGS=32) against an array-based reference model.
module tb_reg_bank_sb;
  localparam int NREGS = 32;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [AW-1:0]    read_reg1 = '0, read_reg2 = '0, write_reg = '0, mark_reg = '0;
  logic             wreg = 1'b0, mark = 1'b0;
  logic [WIDTH-1:0] write_data = '0;
  logic [WIDTH-1:0] read_data1, read_data2;
  logic             pend1, pend2, ready;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [WIDTH-1:0] m_regs [NREGS];
  bit               m_pend [NREGS];
  bit               m_ready;
  int               m_edges;

  reg_bank_sb #(.NREGS(NREGS), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_reg(write_reg), .wreg(wreg), .write_data(write_data),
    .mark_reg(mark_reg), .mark(mark),
    .pend1(pend1), .pend2(pend2), .ready(ready)
  );

  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] exp_data(input logic [AW-1:0] r);
    if (!m_ready || reset || r == 0) return '0;
`ifdef REG_BANK_BYPASS_EN
    if (wreg && write_reg != 0 && r == write_reg) return write_data;
`endif
    return m_regs[r];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] r);
    if (!m_ready || reset) return 1'b0;
`ifdef REG_BANK_BYPASS_EN
    if (wreg && write_reg != 0 && r == write_reg && !(mark && mark_reg == write_reg))
      return 1'b0;
`endif
    return m_pend[r];
  endfunction

  task automatic chk_w(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check(input string tag);
    chk_w({tag, ".ready"}, WIDTH'(ready), WIDTH'(m_ready && !reset));
    chk_w({tag, ".rd1"},   read_data1,    exp_data(read_reg1));
    chk_w({tag, ".rd2"},   read_data2,    exp_data(read_reg2));
    chk_w({tag, ".pend1"}, WIDTH'(pend1), WIDTH'(exp_pend(read_reg1)));
    chk_w({tag, ".pend2"}, WIDTH'(pend2), WIDTH'(exp_pend(read_reg2)));
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (reset) begin
      m_ready = 0; m_edges = 0;
      for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == NREGS - 1) m_ready = 1;
    end else begin
      if (wreg && write_reg != 0) begin
        m_regs[write_reg] = write_data;
        m_pend[write_reg] = 0;
      end
      if (mark && mark_reg != 0) m_pend[mark_reg] = 1;
    end
  endtask

  task automatic tick(input string tag);
    #1 check(tag);
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wreg = 0; mark = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle();
    #1 check("reset_async");
    model_edge();
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic sweep(input string tag);
    int budget = 0;
    while (!m_ready && budget < 40) begin tick(tag); budget++; end
  endtask

  initial begin
    // 1: sweep, then every index reads zero
    do_reset();
    wreg = 1; write_reg = 5'd3; write_data = 32'hAAAA55AA;  // 3: ignored pre-ready
    mark = 1; mark_reg = 5'd3;
    sweep("sweep");
    idle();
    for (int r = 0; r < NREGS; r++) begin
      read_reg1 = AW'(r); read_reg2 = AW'(NREGS - 1 - r);
      tick("zero_read");
    end

    // 2: write r5 and r0
    wreg = 1; write_reg = 5'd5; write_data = 32'hDEADBEEF; tick("wr_r5");
    write_reg = 5'd0; write_data = 32'h12345678;           tick("wr_r0");
    idle(); read_reg1 = 5'd5; read_reg2 = 5'd0;             tick("rd_r5_r0");
    read_reg1 = 5'd3;                                        tick("rd_r3_preready");

    // 4: scoreboard
    read_reg1 = 5'd7; mark = 1; mark_reg = 5'd7;            tick("mark_r7");
    idle();                                                  tick("pend_r7");
    wreg = 1; write_reg = 5'd7; write_data = 32'h1;          tick("wr_r7");
    idle();                                                  tick("clr_r7");
    read_reg2 = 5'd9; wreg = 1; write_reg = 5'd9; write_data = 32'h99;
    mark = 1; mark_reg = 5'd9;                               tick("mark_wr_r9");
    idle();                                                  tick("r9_after");

    // 6: same-cycle read of a writeback target
    read_reg1 = 5'd6; wreg = 1; write_reg = 5'd6; write_data = 32'hCAFE; tick("byp_r6");
    idle();                                                  tick("byp_r6_next");

    // 5: mid-run reset
    wreg = 1; write_reg = 5'd4; write_data = 32'h55; tick("wr_r4");
    idle(); mark = 1; mark_reg = 5'd4; read_reg1 = 5'd4;   tick("mark_r4");
    idle();
    do_reset();
    sweep("resweep");
    read_reg1 = 5'd4; read_reg2 = 5'd9;                      tick("r4_cleared");

    // random traffic, with an occasional reset
    for (int n = 0; n < 600; n++) begin
      read_reg1  = AW'($urandom_range(0, NREGS - 1));
      read_reg2  = AW'($urandom_range(0, NREGS - 1));
      wreg       = ($urandom_range(0, 2) != 0);
      write_reg  = AW'($urandom_range(0, NREGS - 1));
      write_data = $urandom;
      mark       = ($urandom_range(0, 3) == 0);
      mark_reg   = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, NREGS - 1));
      if (n % 4 == 0) read_reg1 = write_reg;
      if (n == 300) do_reset();
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
